ycr_reset_seq_ctrl: RTL and testbench
=====================================

# ycr_reset_seq_ctrl

Reset sequencer that generates per-domain active-low reset requests and releases them in a fixed order. It drives the `reset_n_in` inputs of downstream reset buffer/sync cells and consumes their synchronized `reset_n_status` feedback as acknowledgements. It sits in the core top-level reset tree between the software/debug reset request sources and the per-domain reset cells.

## Interface
- `NUM_DOMAINS`, default 3: number of reset domains; domain 0 is released first; must be ≥1.
- `HOLD_CYCLES`, default 16: cycles all domains stay asserted after assertion is acknowledged; must be ≥1.
- `ACK_TIMEOUT`, default 255: maximum cycles spent waiting for a status acknowledge; must be ≥1.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `test_mode` in 1: scan/test mode select.
- `test_rst_n` in 1: test reset, drives all domain outputs when `test_mode`=1.
- `sw_rst_req` in 1: software reset request, level-sampled.
- `dbg_rst_req` in 1: debug reset request, level-sampled.
- `domain_rst_n` out NUM_DOMAINS: per-domain active-low reset request.
- `domain_status` in NUM_DOMAINS: per-domain reset status, 1 = domain out of reset; already synchronized to `clk`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `seq_done` out 1: one-cycle pulse when a sequence completes.
- `timeout_err` out 1: sticky, set on any acknowledge timeout.
- `rst_cause` out 2: cause of the last sequence: 00 POR, 01 SW, 10 DBG, 11 SW+DBG.

## Operation
- States: IDLE, ASSERT, HOLD, RELEASE, DONE.
- Internal registered vector `dom_q[NUM_DOMAINS-1:0]`. `domain_rst_n` = `test_mode` ? {NUM_DOMAINS{test_rst_n}} : `dom_q`. The FSM runs identically regardless of `test_mode`.
- `rst`=1, on each clock edge: `dom_q`=0, state=HOLD, counter=0, domain index=0, `timeout_err`=0, `rst_cause`=00, `seq_done`=0. `busy`=1 because the state is not IDLE.
- IDLE: `dom_q` is all ones. If `sw_rst_req` or `dbg_rst_req` is high:
  - latch `rst_cause`={dbg,sw};
  - clear `timeout_err`;
  - `dom_q`=0, counter=0;
  - go to ASSERT.
- ASSERT: wait for `domain_status`==0.
  - On that condition, counter=0 and go to HOLD.
  - If the counter reaches ACK_TIMEOUT first, set `timeout_err`, counter=0 and go to HOLD.
- HOLD: increment the counter. When counter==HOLD_CYCLES-1: index=0, counter=0, set `dom_q[0]`=1, go to RELEASE.
- RELEASE: wait for `domain_status[index]`==1, or for counter==ACK_TIMEOUT (which also sets `timeout_err`). Then:
  - if index==NUM_DOMAINS-1, go to DONE;
  - otherwise index++, set `dom_q[index+1]`=1, counter=0.
- DONE: `seq_done`=1 for this cycle only, then go to IDLE.
- Requests are ignored outside IDLE. A request held high continuously restarts a new sequence on the first IDLE cycle.
- Counter width: $clog2(max(HOLD_CYCLES, ACK_TIMEOUT)+1). The counter saturates and never wraps.
- Bits of `dom_q` that have been released are never re-asserted until the next ASSERT.

## Timing
- All outputs except `domain_rst_n` in test mode are registered. `domain_rst_n` in test mode is combinational from `test_rst_n`/`test_mode`.
- Request sampled high in IDLE at edge T: `domain_rst_n`=0 and `busy`=1 after edge T.
- Status all-zero at edge A in ASSERT: HOLD lasts exactly HOLD_CYCLES cycles. `domain_rst_n[0]` rises HOLD_CYCLES edges after A.
- `domain_status[i]` seen high at edge E: `domain_rst_n[i+1]` rises after edge E, so there is one cycle per domain plus the acknowledge latency.
- Timeout: `timeout_err` rises after the edge where counter==ACK_TIMEOUT, i.e. ACK_TIMEOUT+1 cycles after the wait began.
- After release of the last domain is acknowledged: DONE for 1 cycle (`seq_done`=1), then IDLE (`busy`=0).
- Post-`rst` sequence length with immediate acknowledges and NUM_DOMAINS=3, HOLD_CYCLES=16: 16 HOLD + 3 RELEASE + 1 DONE = 20 cycles before `busy`=0.
- `rst` asserted mid-sequence: takes effect on the next edge and restarts from HOLD with all domains asserted.

## Test plan
- POR: hold `rst` 2 cycles, status follows outputs with 2-cycle delay. Required: `domain_rst_n`=000 during reset; bits rise 0→1→2 in order; `seq_done` pulses once; `rst_cause`=00; `timeout_err`=0.
- SW request: 1-cycle `sw_rst_req` pulse in IDLE. Required: outputs drop to 000 next cycle; HOLD 16 cycles after status reads 000; ordered release; `rst_cause`=01.
- Simultaneous `sw_rst_req`+`dbg_rst_req`. Required: `rst_cause`=11. A second request pulse during HOLD is ignored, giving exactly one `seq_done`.
- Timeout: tie `domain_status[1]`=0, ACK_TIMEOUT=8. Required: `timeout_err` rises 9 cycles after `domain_rst_n[1]` rises; domain 2 is still released; `seq_done` pulses; next request clears `timeout_err`.
- Test mode: `test_mode`=1, toggle `test_rst_n`. Required: all `domain_rst_n` bits follow `test_rst_n` combinationally regardless of FSM state; deasserting `test_mode` restores `dom_q`.
- Reset mid-RELEASE: assert `rst` while domain 1 is awaiting acknowledge. Required: outputs 000 after the next edge, then a fresh POR sequence with `rst_cause`=00.

Source files
------------

// File: rtl/ycr_reset_seq_ctrl.sv
// Ordered reset sequencer: asserts all domain resets, holds them, then releases
// domain 0..N-1 one at a time, waiting for each domain's status acknowledge.
module ycr_reset_seq_ctrl #(
    parameter int unsigned NUM_DOMAINS = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   test_mode,
    input  logic                   test_rst_n,
    input  logic                   sw_rst_req,
    input  logic                   dbg_rst_req,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    input  logic [NUM_DOMAINS-1:0] domain_status,
    output logic                   busy,
    output logic                   seq_done,
    output logic                   timeout_err,
    output logic [1:0]             rst_cause
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        HOLD,
        RELEASE,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_inc;
    logic [IW-1:0]          idx;
    logic [NUM_DOMAINS-1:0] dom_q;
    logic [NUM_DOMAINS-1:0] next_bit;
    logic                   ack;
    logic                   cnt_expired;
    logic                   hold_end;
    logic                   last_dom;

    // Scan/test reset bypasses the sequencer without disturbing its state.
    assign domain_rst_n = test_mode ? {NUM_DOMAINS{test_rst_n}} : dom_q;

    always_comb begin
        next_bit = '0;
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            if (i == 32'(idx) + 1) next_bit[i] = 1'b1;
        end
        cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
        ack         = domain_status[idx];
        cnt_expired = (cnt == CW'(ACK_TIMEOUT));
        hold_end    = (cnt == CW'(HOLD_CYCLES - 1));
        last_dom    = (idx == IW'(NUM_DOMAINS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HOLD;
            dom_q       <= '0;
            cnt         <= '0;
            idx         <= '0;
            timeout_err <= 1'b0;
            rst_cause   <= 2'b00;
            seq_done    <= 1'b0;
            busy        <= 1'b1;
        end else begin
            seq_done <= 1'b0;
            case (state)
                IDLE: begin
                    dom_q <= '1;
                    if (sw_rst_req || dbg_rst_req) begin
                        rst_cause   <= {dbg_rst_req, sw_rst_req};
                        timeout_err <= 1'b0;
                        dom_q       <= '0;
                        cnt         <= '0;
                        state       <= ASSERT;
                        busy        <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (domain_status == '0) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else if (cnt_expired) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HOLD: begin
                    if (hold_end) begin
                        idx      <= '0;
                        cnt      <= '0;
                        dom_q[0] <= 1'b1;
                        state    <= RELEASE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RELEASE: begin
                    // A timed-out domain is released past anyway so the rest still come up.
                    if (ack || cnt_expired) begin
                        if (!ack) timeout_err <= 1'b1;
                        cnt <= '0;
                        if (last_dom) begin
                            state    <= DONE;
                            seq_done <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            dom_q <= dom_q | next_bit;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ycr_reset_seq_ctrl.sv
// Directed bench for ycr_reset_seq_ctrl: status modelled as domain_rst_n delayed
// by two clocks, with an optional per-domain stuck-at-0 mask.
module tb_ycr_reset_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       test_mode = 1'b0;
    logic       test_rst_n = 1'b0;
    logic       sw = 1'b0;
    logic       dbg = 1'b0;
    logic [2:0] drn;
    logic [2:0] status;
    logic [2:0] s1 = '0;
    logic [2:0] s2 = '0;
    logic [2:0] tie0 = '0;
    logic       busy;
    logic       seq_done;
    logic       timeout_err;
    logic [1:0] rst_cause;

    int total = 0;
    int bad   = 0;

    ycr_reset_seq_ctrl #(
        .NUM_DOMAINS(3),
        .HOLD_CYCLES(16),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .test_mode    (test_mode),
        .test_rst_n   (test_rst_n),
        .sw_rst_req   (sw),
        .dbg_rst_req  (dbg),
        .domain_rst_n (drn),
        .domain_status(status),
        .busy         (busy),
        .seq_done     (seq_done),
        .timeout_err  (timeout_err),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s1 <= drn;
        s2 <= s1;
    end
    assign status = s2 & ~tie0;

    typedef struct {
        logic       sw;
        logic       dbg;
        logic [1:0] cause;
        int         repulse;
    } req_vec_t;

    typedef struct {
        logic       tm;
        logic       trn;
        logic [2:0] exp_idle;
        logic [2:0] exp_hold;
    } tm_vec_t;

    req_vec_t rv[3];
    tm_vec_t  tv[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until busy falls, recording the step index of each release and event.
    task automatic run_seq(input int repulse_at, output int t0, output int t1, output int t2,
                           output int tto, output int tdone, output int ndone, output int ord_err);
        int n;
        logic [2:0] prev;
        n = 0; t0 = -1; t1 = -1; t2 = -1; tto = -1; tdone = -1; ndone = 0; ord_err = 0;
        prev = drn;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
            if (repulse_at != 0 && n == repulse_at) sw = 1'b1;
            if (repulse_at != 0 && n == repulse_at + 1) sw = 1'b0;
            if (drn[0] === 1'b1 && t0 < 0) t0 = n;
            if (drn[1] === 1'b1 && t1 < 0) t1 = n;
            if (drn[2] === 1'b1 && t2 < 0) t2 = n;
            if (timeout_err === 1'b1 && tto < 0) tto = n;
            if (seq_done === 1'b1) ndone++;
            if (!(drn inside {3'b000, 3'b001, 3'b011, 3'b111}) || drn < prev) ord_err++;
            prev = drn;
            if (busy === 1'b0) tdone = n;
        end
    endtask

    task automatic do_req(input logic s, input logic d, input string tag);
        sw  = s;
        dbg = d;
        step();
        sw  = 1'b0;
        dbg = 1'b0;
        check({tag, "_assert_drn"}, 32'(drn), 32'h0);
        check({tag, "_assert_busy"}, 32'(busy), 32'h1);
        check({tag, "_terr_clear"}, 32'(timeout_err), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, tto, tdone, ndone, oerr, n;

        rv[0] = '{sw: 1'b1, dbg: 1'b0, cause: 2'b01, repulse: 0};
        rv[1] = '{sw: 1'b0, dbg: 1'b1, cause: 2'b10, repulse: 0};
        rv[2] = '{sw: 1'b1, dbg: 1'b1, cause: 2'b11, repulse: 10};

        tv[0] = '{tm: 1'b1, trn: 1'b0, exp_idle: 3'b000, exp_hold: 3'b000};
        tv[1] = '{tm: 1'b1, trn: 1'b1, exp_idle: 3'b111, exp_hold: 3'b111};
        tv[2] = '{tm: 1'b1, trn: 1'b0, exp_idle: 3'b000, exp_hold: 3'b000};
        tv[3] = '{tm: 1'b0, trn: 1'b1, exp_idle: 3'b111, exp_hold: 3'b000};
        tv[4] = '{tm: 1'b0, trn: 1'b0, exp_idle: 3'b111, exp_hold: 3'b000};

        // Power-on reset, two cycles
        rst = 1'b1;
        step();
        check("por_r1_drn", 32'(drn), 32'h0);
        check("por_r1_busy", 32'(busy), 32'h1);
        step();
        check("por_r2_drn", 32'(drn), 32'h0);
        check("por_r2_seqdone", 32'(seq_done), 32'h0);
        check("por_r2_terr", 32'(timeout_err), 32'h0);
        check("por_r2_cause", 32'(rst_cause), 32'h0);
        rst = 1'b0;
        run_seq(0, t0, t1, t2, tto, tdone, ndone, oerr);
        check("por_t0", 32'(t0), 32'd16);
        check("por_t1", 32'(t1), 32'd19);
        check("por_t2", 32'(t2), 32'd22);
        check("por_tdone", 32'(tdone), 32'd26);
        check("por_ndone", 32'(ndone), 32'd1);
        check("por_order", 32'(oerr), 32'd0);
        check("por_cause", 32'(rst_cause), 32'h0);
        check("por_terr", 32'(timeout_err), 32'h0);
        check("por_final_drn", 32'(drn), 32'h7);

        // Test-mode override while idle
        for (int i = 0; i < 5; i++) begin
            test_mode  = tv[i].tm;
            test_rst_n = tv[i].trn;
            #1;
            check($sformatf("tm_idle_%0d", i), 32'(drn), 32'(tv[i].exp_idle));
        end

        // Request table: cause encoding, timing, ignored request during HOLD
        for (int i = 0; i < 3; i++) begin
            do_req(rv[i].sw, rv[i].dbg, $sformatf("req%0d", i));
            run_seq(rv[i].repulse, t0, t1, t2, tto, tdone, ndone, oerr);
            check($sformatf("req%0d_t0", i), 32'(t0), 32'd19);
            check($sformatf("req%0d_t1", i), 32'(t1), 32'd22);
            check($sformatf("req%0d_t2", i), 32'(t2), 32'd25);
            check($sformatf("req%0d_tdone", i), 32'(tdone), 32'd29);
            check($sformatf("req%0d_ndone", i), 32'(ndone), 32'd1);
            check($sformatf("req%0d_order", i), 32'(oerr), 32'd0);
            check($sformatf("req%0d_cause", i), 32'(rst_cause), 32'(rv[i].cause));
            check($sformatf("req%0d_terr", i), 32'(timeout_err), 32'h0);
        end
        step();
        check("repulse_no_restart", 32'(busy), 32'h0);

        // Acknowledge timeout on domain 1
        tie0 = 3'b010;
        do_req(1'b1, 1'b0, "to");
        run_seq(0, t0, t1, t2, tto, tdone, ndone, oerr);
        tie0 = 3'b000;
        check("to_t1", 32'(t1), 32'd22);
        check("to_delay", 32'(tto - t1), 32'd9);
        check("to_t2", 32'(t2), 32'd31);
        check("to_tdone", 32'(tdone), 32'd35);
        check("to_ndone", 32'(ndone), 32'd1);
        check("to_sticky", 32'(timeout_err), 32'h1);
        do_req(1'b0, 1'b1, "to_clear");
        run_seq(0, t0, t1, t2, tto, tdone, ndone, oerr);
        check("to_clear_tdone", 32'(tdone), 32'd29);
        check("to_clear_terr", 32'(timeout_err), 32'h0);

        // Test-mode override mid-HOLD; FSM timing must be unaffected
        do_req(1'b1, 1'b0, "tmh");
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 5; i++) begin
            test_mode  = tv[i].tm;
            test_rst_n = tv[i].trn;
            #1;
            check($sformatf("tm_hold_%0d", i), 32'(drn), 32'(tv[i].exp_hold));
        end
        run_seq(0, t0, t1, t2, tto, tdone, ndone, oerr);
        check("tmh_t0", 32'(t0), 32'd11);
        check("tmh_tdone", 32'(tdone), 32'd21);
        check("tmh_ndone", 32'(ndone), 32'd1);

        // rst while domain 1 awaits acknowledge
        do_req(1'b1, 1'b0, "mid");
        n = 0;
        while (drn !== 3'b011 && n < 60) begin
            step();
            n++;
        end
        check("mid_reach_release1", 32'(drn), 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_drn", 32'(drn), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h1);
        check("mid_rst_cause", 32'(rst_cause), 32'h0);
        check("mid_rst_seqdone", 32'(seq_done), 32'h0);
        run_seq(0, t0, t1, t2, tto, tdone, ndone, oerr);
        check("mid_t0", 32'(t0), 32'd16);
        check("mid_t2", 32'(t2), 32'd22);
        check("mid_tdone", 32'(tdone), 32'd26);
        check("mid_ndone", 32'(ndone), 32'd1);
        check("mid_order", 32'(oerr), 32'd0);
        check("mid_cause", 32'(rst_cause), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
